// File: rtl/serial_subtractor_16bit.sv
// Bit-serial subtractor: one bit per clock, LSB first, result a - b - bin after WIDTH cycles.
// Optional zero-result flag port enabled by defining SERIAL_SUBTRACTOR_ZERO_FLAG_EN.
module serial_subtractor_16bit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             overflow
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             br_q;
    logic             a_msb_q;
    logic             b_msb_q;
    logic [CntW-1:0]  cnt_q;

    logic             ai;
    logic             bi;
    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] res_next;
    logic             last_bit;

    // Single-bit full subtractor on the current LSBs of the shifting operands.
    always_comb begin
        ai       = a_q[0];
        bi       = b_q[0];
        d_bit    = ai ^ bi ^ br_q;
        br_next  = (~ai & bi) | (~(ai ^ bi) & br_q);
        res_next = {d_bit, res_q[WIDTH-1:1]};
        last_bit = (cnt_q == CntW'(WIDTH - 1));
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StShift;
            StShift: if (last_bit) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign busy = (state_q != StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            cnt_q    <= '0;
            done     <= 1'b0;
            diff     <= '0;
            bout     <= 1'b0;
            overflow <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
            zero     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        br_q    <= bin;
                        a_msb_q <= a[WIDTH-1];
                        b_msb_q <= b[WIDTH-1];
                        res_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                StShift: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    br_q  <= br_next;
                    res_q <= res_next;
                    cnt_q <= cnt_q + 1'b1;
                    // On the final bit d_bit is the result MSB, so overflow resolves here.
                    if (last_bit) begin
                        diff     <= res_next;
                        bout     <= br_next;
                        overflow <= (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
                        done     <= 1'b1;
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
                        zero     <= (res_next == '0);
`endif
                    end
                end
                StDone: begin
                    done <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_16bit.sv
// Self-checking bench for serial_subtractor_16bit (WIDTH=16) against an arithmetic model.
module tb_serial_subtractor_16bit;

    localparam int unsigned WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             overflow;
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
    logic             zero;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [WIDTH-1:0] exp_prev_diff;

    serial_subtractor_16bit #(
        .WIDTH(WIDTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .bin     (bin),
        .busy    (busy),
        .done    (done),
        .diff    (diff),
        .bout    (bout),
        .overflow(overflow)
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
        ,
        .zero    (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {zero, overflow, bout, diff} computed with plain arithmetic.
    function automatic logic [WIDTH+2:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic c);
        logic [WIDTH-1:0] d;
        logic             bo;
        logic             ov;
        logic             z;
        d  = x - y - {{(WIDTH-1){1'b0}}, c};
        bo = ({1'b0, x} < ({1'b0, y} + {{WIDTH{1'b0}}, c}));
        ov = (x[WIDTH-1] != y[WIDTH-1]) && (d[WIDTH-1] != x[WIDTH-1]);
        z  = (d == '0);
        return {z, ov, bo, d};
    endfunction

    // Drives one operation; must be entered right after a falling edge.
    task automatic do_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob, input logic obin,
                         input bit scramble, output logic [WIDTH-1:0] od, output logic obo,
                         output logic oov, output logic oz, output int lat, output int hold_bad,
                         output logic busy_acc, output logic done_after, output logic busy_after);
        a = oa; b = ob; bin = obin; start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        busy_acc = busy;
        if (scramble) begin
            a   = WIDTH'($urandom);
            b   = WIDTH'($urandom);
            bin = 1'($urandom);
        end
        lat = -1;
        hold_bad = 0;
        for (int k = 1; k <= int'(WIDTH) + 4; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (diff !== exp_prev_diff || busy !== 1'b1) hold_bad++;
        end
        od  = diff;
        obo = bout;
        oov = overflow;
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
        oz  = zero;
`else
        oz  = 1'b0;
`endif
        @(negedge clk);
        done_after = done;
        busy_after = busy;
    endtask

    task automatic test_reset();
        total_cnt += 5;
        if (busy !== 1'b0) $display("FAIL reset busy got %b want 0", busy); else pass_cnt++;
        if (done !== 1'b0) $display("FAIL reset done got %b want 0", done); else pass_cnt++;
        if (diff !== '0) $display("FAIL reset diff got %h want 0", diff); else pass_cnt++;
        if (bout !== 1'b0) $display("FAIL reset bout got %b want 0", bout); else pass_cnt++;
        if (overflow !== 1'b0) $display("FAIL reset overflow got %b want 0", overflow);
        else pass_cnt++;
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
        total_cnt++;
        if (zero !== 1'b0) $display("FAIL reset zero got %b want 0", zero); else pass_cnt++;
`endif
        exp_prev_diff = '0;
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] ta[6] = '{16'h0005, 16'h0000, 16'h8000, 16'h7FFF, 16'h1234, 16'h1234};
        logic [WIDTH-1:0] tb[6] = '{16'h0003, 16'h0001, 16'h0001, 16'hFFFF, 16'h1234, 16'h1234};
        logic             tc[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [WIDTH-1:0] od;
        logic             obo, oov, oz, bacc, dafter, bafter;
        int               lat, hb;
        logic [WIDTH+2:0] e;
        for (int i = 0; i < 6; i++) begin
            e = model(ta[i], tb[i], tc[i]);
            do_op(ta[i], tb[i], tc[i], 1'b0, od, obo, oov, oz, lat, hb, bacc, dafter, bafter);
            total_cnt += 8;
            if (od !== e[WIDTH-1:0]) $display("FAIL dir%0d diff got %h want %h", i, od, e[WIDTH-1:0]);
            else pass_cnt++;
            if (obo !== e[WIDTH]) $display("FAIL dir%0d bout got %b want %b", i, obo, e[WIDTH]);
            else pass_cnt++;
            if (oov !== e[WIDTH+1]) $display("FAIL dir%0d overflow got %b want %b", i, oov, e[WIDTH+1]);
            else pass_cnt++;
            if (lat !== int'(WIDTH)) $display("FAIL dir%0d latency got %0d want %0d", i, lat, WIDTH);
            else pass_cnt++;
            if (dafter !== 1'b0) $display("FAIL dir%0d done_width got %b want 0", i, dafter);
            else pass_cnt++;
            if (bafter !== 1'b0) $display("FAIL dir%0d busy_after got %b want 0", i, bafter);
            else pass_cnt++;
            if (bacc !== 1'b1) $display("FAIL dir%0d busy_accept got %b want 1", i, bacc);
            else pass_cnt++;
            if (hb !== 0) $display("FAIL dir%0d hold_cycles got %0d want 0", i, hb); else pass_cnt++;
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
            total_cnt++;
            if (oz !== e[WIDTH+2]) $display("FAIL dir%0d zero got %b want %b", i, oz, e[WIDTH+2]);
            else pass_cnt++;
`endif
            exp_prev_diff = e[WIDTH-1:0];
        end
    endtask

    // Random operands; inputs are scrambled after acceptance to prove they were captured.
    task automatic test_random();
        logic [WIDTH-1:0] ra, rb, od;
        logic             rc, obo, oov, oz, bacc, dafter, bafter;
        int               lat, hb;
        logic [WIDTH+2:0] e;
        for (int i = 0; i < 40; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            if (i == 0) rb = ra;
            e = model(ra, rb, rc);
            do_op(ra, rb, rc, 1'b1, od, obo, oov, oz, lat, hb, bacc, dafter, bafter);
            total_cnt += 5;
            if (od !== e[WIDTH-1:0])
                $display("FAIL rnd%0d diff %h-%h-%b got %h want %h", i, ra, rb, rc, od, e[WIDTH-1:0]);
            else pass_cnt++;
            if (obo !== e[WIDTH]) $display("FAIL rnd%0d bout got %b want %b", i, obo, e[WIDTH]);
            else pass_cnt++;
            if (oov !== e[WIDTH+1]) $display("FAIL rnd%0d overflow got %b want %b", i, oov, e[WIDTH+1]);
            else pass_cnt++;
            if (lat !== int'(WIDTH)) $display("FAIL rnd%0d latency got %0d want %0d", i, lat, WIDTH);
            else pass_cnt++;
            if (hb !== 0) $display("FAIL rnd%0d hold_cycles got %0d want 0", i, hb); else pass_cnt++;
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
            total_cnt++;
            if (oz !== e[WIDTH+2]) $display("FAIL rnd%0d zero got %b want %b", i, oz, e[WIDTH+2]);
            else pass_cnt++;
`endif
            exp_prev_diff = e[WIDTH-1:0];
        end
    endtask

    task automatic test_ignore_start();
        logic [WIDTH+2:0] e;
        int               lat;
        int               busy_drop;
        e = model(16'h5A5A, 16'h1234, 1'b1);
        a = 16'h5A5A; b = 16'h1234; bin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        busy_drop = 0;
        for (int k = 1; k <= int'(WIDTH) + 4; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (busy !== 1'b1) busy_drop++;
            if (k == 5) begin
                start = 1'b1; a = 16'hFFFF; b = 16'h0000; bin = 1'b0;
            end else begin
                start = 1'b0;
            end
        end
        total_cnt += 5;
        if (diff !== e[WIDTH-1:0]) $display("FAIL ignore diff got %h want %h", diff, e[WIDTH-1:0]);
        else pass_cnt++;
        if (bout !== e[WIDTH]) $display("FAIL ignore bout got %b want %b", bout, e[WIDTH]);
        else pass_cnt++;
        if (lat !== int'(WIDTH)) $display("FAIL ignore latency got %0d want %0d", lat, WIDTH);
        else pass_cnt++;
        if (busy_drop !== 0) $display("FAIL ignore busy_drop got %0d want 0", busy_drop);
        else pass_cnt++;
        @(negedge clk);
        if (busy !== 1'b0) $display("FAIL ignore busy_after got %b want 0", busy); else pass_cnt++;
        exp_prev_diff = e[WIDTH-1:0];
    endtask

    task automatic test_mid_reset();
        logic [WIDTH-1:0] od;
        logic             obo, oov, oz, bacc, dafter, bafter;
        int               lat, hb, spurious;
        do_op(16'h1234, 16'h0001, 1'b0, 1'b0, od, obo, oov, oz, lat, hb, bacc, dafter, bafter);
        total_cnt++;
        if (od !== 16'h1233) $display("FAIL mrst_pre diff got %h want 1233", od); else pass_cnt++;
        a = 16'h4321; b = 16'h0001; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total_cnt += 5;
        if (busy !== 1'b0) $display("FAIL mrst busy got %b want 0", busy); else pass_cnt++;
        if (done !== 1'b0) $display("FAIL mrst done got %b want 0", done); else pass_cnt++;
        if (diff !== '0) $display("FAIL mrst diff got %h want 0", diff); else pass_cnt++;
        if (bout !== 1'b0) $display("FAIL mrst bout got %b want 0", bout); else pass_cnt++;
        if (overflow !== 1'b0) $display("FAIL mrst overflow got %b want 0", overflow);
        else pass_cnt++;
        spurious = 0;
        for (int k = 0; k < int'(WIDTH); k++) begin
            @(negedge clk);
            if (done !== 1'b0) spurious++;
            if (k == 2) rst = 1'b0;
        end
        total_cnt++;
        if (spurious !== 0) $display("FAIL mrst done_pulses got %0d want 0", spurious);
        else pass_cnt++;
        exp_prev_diff = '0;
        // Release reset and raise start together so the first post-reset edge accepts.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        do_op(16'h0005, 16'h0003, 1'b0, 1'b0, od, obo, oov, oz, lat, hb, bacc, dafter, bafter);
        total_cnt += 3;
        if (od !== 16'h0002) $display("FAIL mrst_post diff got %h want 0002", od); else pass_cnt++;
        if (lat !== int'(WIDTH)) $display("FAIL mrst_post latency got %0d want %0d", lat, WIDTH);
        else pass_cnt++;
        if (hb !== 0) $display("FAIL mrst_post hold_cycles got %0d want 0", hb); else pass_cnt++;
        exp_prev_diff = 16'h0002;
    endtask

    // Operations issued with no idle gap beyond the mandatory DONE->IDLE cycle.
    task automatic test_back_to_back();
        logic [WIDTH-1:0] od, ra, rb;
        logic             obo, oov, oz, bacc, dafter, bafter;
        int               lat, hb;
        logic [WIDTH+2:0] e;
        for (int i = 0; i < 4; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            e = model(ra, rb, 1'b0);
            do_op(ra, rb, 1'b0, 1'b0, od, obo, oov, oz, lat, hb, bacc, dafter, bafter);
            total_cnt += 3;
            if (bacc !== 1'b1) $display("FAIL b2b%0d accepted got %b want 1", i, bacc); else pass_cnt++;
            if (lat !== int'(WIDTH)) $display("FAIL b2b%0d latency got %0d want %0d", i, lat, WIDTH);
            else pass_cnt++;
            if (od !== e[WIDTH-1:0]) $display("FAIL b2b%0d diff got %h want %h", i, od, e[WIDTH-1:0]);
            else pass_cnt++;
            exp_prev_diff = e[WIDTH-1:0];
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        exp_prev_diff = '0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_directed();
        test_random();
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/serial_subtractor_16bit.md
SERIAL_SUBTRACTOR_16BIT -- requirements
Module: serial_subtractor_16bit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width; legal range 2..32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  minuend, captured when start is accepted.
REQ-006 SHALL have port b  input  WIDTH  subtrahend, captured when start is accepted.
REQ-007 SHALL have port bin  input  1  borrow-in, captured when start is accepted.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress (SHIFT or DONE).
REQ-009 SHALL have port done  output  1  one-cycle pulse marking result valid.
REQ-010 SHALL have port diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
REQ-011 SHALL have port bout  output  1  borrow-out; 1 when a < b + bin unsigned.
REQ-012 SHALL have port overflow  output  1  two's-complement overflow: (a[MSB] != b[MSB]) and (diff[MSB] != a[MSB]).
REQ-013 SHALL have port zero  output  1  present only per REQ-027.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-015 IDLE with start=1 at a rising edge SHALL capture a, b, bin into internal registers, clear bit counter, enter SHIFT.
REQ-016 Each SHIFT edge SHALL process one bit, LSB first: d = ai ^ bi ^ br; br_next = (~ai & bi) | (~(ai ^ bi) & br); d shifted into internal result register.
REQ-017 After exactly WIDTH SHIFT edges SHALL enter DONE and, on that same edge, load diff, bout, overflow (and zero) from internal state and set done=1.
REQ-018 Latency: done SHALL go high on the WIDTH-th rising edge after the edge that accepted start, and stay high exactly one cycle.
REQ-019 DONE SHALL return to IDLE on the next edge, clearing done; throughput one operation per WIDTH+2 cycles.
REQ-020 start while busy=1 SHALL be ignored; no queuing, captured operands unchanged.
REQ-021 Inputs a, b, bin changing after acceptance SHALL NOT affect the result.
REQ-022 diff, bout, overflow SHALL hold the previous result during SHIFT and until the next completion.
REQ-023 busy SHALL be high from the accept edge through the cycle done is high, low otherwise.

Reset
REQ-024 rst=1 SHALL immediately force state IDLE; busy, done, diff, bout, overflow, zero = 0; counter and internal registers cleared.
REQ-025 Reset mid-operation SHALL abort with no done pulse; first start after release SHALL behave per REQ-015.
REQ-026 start sampled in the first edge after rst deasserts SHALL be accepted normally.

Configuration
REQ-027 Macro SERIAL_SUBTRACTOR_ZERO_FLAG_EN: defined -> port zero exists, loaded with (diff == 0) per REQ-017, held per REQ-022; undefined -> port zero and its logic absent, all other behaviour identical.

Verification (WIDTH=16)
REQ-028 a=0x0005, b=0x0003, bin=0 -> diff=0x0002, bout=0, overflow=0; done exactly 16 edges after accept, one cycle wide.
REQ-029 a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, overflow=0; a=0x8000, b=0x0001 -> diff=0x7FFF, bout=0, overflow=1.
REQ-030 a=0x7FFF, b=0xFFFF, bin=0 -> diff=0x8000, bout=1, overflow=1.
REQ-031 a=0x1234, b=0x1234, bin=1 -> diff=0xFFFF, bout=1; with bin=0 -> diff=0x0000, zero=1 (macro defined).
REQ-032 start re-pulsed and a/b changed at SHIFT cycle 5 -> ignored; result matches original operands; busy stays high.
REQ-033 rst asserted at SHIFT cycle 8 -> all outputs 0 asynchronously, no done; subsequent 0x0005-0x0003 yields 0x0002.
